// File: rtl/player_sprite_render.sv
// Per-player sprite renderer: latches animation/position once per video frame,
// maps them to a sprite-ROM frame index and runs a 3-stage ROM lookup against the raster.
module player_sprite_render #(
  parameter int          COL_W       = 5,
  parameter int          ROW_W       = 6,
  parameter int          FRM_W       = 3,
  parameter int          FRAME_SHIFT = 2,
  parameter int          LOOP_DIV    = 6,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic                             pix_en,
  input  logic [9:0]                       hcount,
  input  logic [9:0]                       vcount,
  input  logic [3:0]                       anim_state,
  input  logic [5:0]                       anim_frame,
  input  logic [9:0]                       pos_x,
  input  logic [9:0]                       pos_y,
  input  logic                             facing,
  output logic [4+FRM_W+ROW_W+COL_W-1:0]   rom_addr,
  input  logic [11:0]                      rom_data,
  output logic [11:0]                      pix_color,
  output logic                             pix_opaque,
  output logic                             pix_valid
);

  localparam int DIV_W = (LOOP_DIV > 1) ? $clog2(LOOP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LOOP_DIV - 1);
  localparam logic [5:0] FRM_MAX = 6'((2 ** FRM_W) - 1);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WALK = 4'd1,
    ST_JUMP = 4'd2,
    ST_ATK1 = 4'd3,
    ST_ATK2 = 4'd4,
    ST_HIT  = 4'd5,
    ST_LOSE = 4'd6
  } anim_t;

  // Shadow registers
  anim_t            r_state;
  logic [FRM_W-1:0] r_frame;
  logic [9:0]       r_pos_x;
  logic [9:0]       r_pos_y;
  logic             r_facing;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_loop;

  // Pipeline registers
  logic r_in_box_d1, r_in_box_d2;
  logic r_pix_en_d1, r_pix_en_d2;

  anim_t            w_new_state;
  logic [DIV_W-1:0] w_div_nxt;
  logic [1:0]       w_loop_nxt;
  logic [5:0]       w_shifted;
  logic [FRM_W-1:0] w_frame_nxt;
  logic [10:0]      w_dx;
  logic [10:0]      w_dy;
  logic             w_in_box;
  logic [COL_W-1:0] w_col;
  logic             w_opaque;

  always_comb begin
    w_new_state = (anim_state > 4'd6) ? ST_IDLE : anim_t'(anim_state);
    w_div_nxt   = r_div;
    w_loop_nxt  = r_loop;
    // A state change restarts the loop so a new animation always begins at frame 0.
    if (w_new_state != r_state) begin
      w_div_nxt  = '0;
      w_loop_nxt = '0;
    end else if (r_div == DIV_LAST) begin
      w_div_nxt  = '0;
      w_loop_nxt = (w_new_state == ST_IDLE) ? {1'b0, ~r_loop[0]} : r_loop + 2'd1;
    end else begin
      w_div_nxt = r_div + DIV_W'(1);
    end

    w_shifted   = anim_frame >> FRAME_SHIFT;
    w_frame_nxt = '0;
    case (w_new_state)
      ST_IDLE, ST_WALK: w_frame_nxt = FRM_W'(w_loop_nxt);
      ST_JUMP, ST_ATK1, ST_ATK2:
        w_frame_nxt = (w_shifted > FRM_MAX) ? FRM_MAX[FRM_W-1:0] : w_shifted[FRM_W-1:0];
      default: w_frame_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_frame  <= '0;
      r_pos_x  <= '0;
      r_pos_y  <= '0;
      r_facing <= 1'b0;
      r_div    <= '0;
      r_loop   <= '0;
    end else if (frame_start) begin
      r_state  <= w_new_state;
      r_frame  <= w_frame_nxt;
      r_pos_x  <= pos_x;
      r_pos_y  <= pos_y;
      r_facing <= facing;
      r_div    <= w_div_nxt;
      r_loop   <= w_loop_nxt;
    end
  end

  // 11-bit differences: a raster left of/above the sprite sets the top bit and falls out of the box.
  always_comb begin
    w_dx     = {1'b0, hcount} - {1'b0, r_pos_x};
    w_dy     = {1'b0, vcount} - {1'b0, r_pos_y};
    w_in_box = (w_dx[10:COL_W] == '0) && (w_dy[10:ROW_W] == '0);
    w_col    = r_facing ? ~w_dx[COL_W-1:0] : w_dx[COL_W-1:0];
    w_opaque = r_in_box_d2 & r_pix_en_d2 & (rom_data != TRANSPARENT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr    <= '0;
      r_in_box_d1 <= 1'b0;
      r_pix_en_d1 <= 1'b0;
      r_in_box_d2 <= 1'b0;
      r_pix_en_d2 <= 1'b0;
      pix_color   <= '0;
      pix_opaque  <= 1'b0;
      pix_valid   <= 1'b0;
    end else begin
      if (w_in_box)
        rom_addr <= {r_state, r_frame, w_dy[ROW_W-1:0], w_col};
      r_in_box_d1 <= w_in_box;
      r_pix_en_d1 <= pix_en;
      r_in_box_d2 <= r_in_box_d1;
      r_pix_en_d2 <= r_pix_en_d1;
      pix_opaque  <= w_opaque;
      pix_color   <= w_opaque ? rom_data : 12'h000;
      pix_valid   <= r_pix_en_d2;
    end
  end

endmodule

// File: tb/tb_player_sprite_render.sv
// Directed bench for player_sprite_render with a synchronous ROM model
// returning either the column field or a fixed color.
module tb_player_sprite_render;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        pix_en;
  logic [9:0]  hcount, vcount;
  logic [3:0]  anim_state;
  logic [5:0]  anim_frame;
  logic [9:0]  pos_x, pos_y;
  logic        facing;
  logic [17:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] pix_color;
  logic        pix_opaque;
  logic        pix_valid;

  int total = 0;
  int bad   = 0;

  logic        rom_mode = 1'b0;   // 0: data = column field, 1: data = rom_const
  logic [11:0] rom_const = 12'h000;

  player_sprite_render #(
    .COL_W(5), .ROW_W(6), .FRM_W(3), .FRAME_SHIFT(2), .LOOP_DIV(6), .TRANSPARENT(12'hF0F)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .anim_state(anim_state), .anim_frame(anim_frame),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_color(pix_color), .pix_opaque(pix_opaque),
    .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= rom_mode ? rom_const : {7'b0, rom_addr[4:0]};

  function automatic logic [17:0] mk(input int st, input int fr, input int row, input int col);
    return {4'(st), 3'(fr), 6'(row), 5'(col)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input int st, input int fr, input int x, input int y, input logic f);
    anim_state  = 4'(st);
    anim_frame  = 6'(fr);
    pos_x       = 10'(x);
    pos_y       = 10'(y);
    facing      = f;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Drive one visible pixel; on return rom_addr for it is visible, raster parked off-sprite.
  task automatic pix(input int h, input int v);
    pix_en = 1'b1;
    hcount = 10'(h);
    vcount = 10'(v);
    tick();
    pix_en = 1'b0;
    hcount = 10'd1000;
    vcount = 10'd1000;
  endtask

  task automatic drain();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 0; pix_en = 0; hcount = 0; vcount = 0;
    anim_state = 0; anim_frame = 0; pos_x = 0; pos_y = 0; facing = 0;
    tick(); tick();
    total++;
    if (rom_addr !== 18'd0 || pix_color !== 12'd0 || pix_opaque !== 1'b0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs addr=%h color=%h opaque=%b valid=%b exp all 0",
               rom_addr, pix_color, pix_opaque, pix_valid);
    end
    reset = 1'b0;
    tick();
    pix(3, 2);
    total++;
    if (rom_addr !== mk(0, 0, 2, 3)) begin
      bad++; $display("FAIL reset_shadow got=%h exp=%h", rom_addr, mk(0, 0, 2, 3));
    end
    drain();
    total++;
    if (pix_opaque !== 1'b1 || pix_color !== 12'd3 || pix_valid !== 1'b1) begin
      bad++; $display("FAIL reset_pixel opaque=%b color=%h valid=%b exp 1 003 1",
                      pix_opaque, pix_color, pix_valid);
    end
  endtask

  task automatic test_basic_draw();
    rom_mode = 1'b0;
    latch(1, 0, 100, 50, 1'b0);
    pix(100, 50);
    total++;
    if (rom_addr !== mk(1, 0, 0, 0)) begin
      bad++; $display("FAIL draw_addr0 got=%h exp=%h", rom_addr, mk(1, 0, 0, 0));
    end
    drain();
    total++;
    if (pix_opaque !== 1'b1 || pix_color !== 12'd0 || pix_valid !== 1'b1) begin
      bad++; $display("FAIL draw_pix0 opaque=%b color=%h valid=%b exp 1 000 1",
                      pix_opaque, pix_color, pix_valid);
    end
    pix(110, 53);
    total++;
    if (rom_addr !== mk(1, 0, 3, 10)) begin
      bad++; $display("FAIL draw_addr1 got=%h exp=%h", rom_addr, mk(1, 0, 3, 10));
    end
    drain();
    total++;
    if (pix_opaque !== 1'b1 || pix_color !== 12'd10) begin
      bad++; $display("FAIL draw_pix1 opaque=%b color=%h exp 1 00a", pix_opaque, pix_color);
    end
    pix(132, 50);
    total++;
    if (rom_addr !== mk(1, 0, 3, 10)) begin
      bad++; $display("FAIL draw_hold got=%h exp=%h", rom_addr, mk(1, 0, 3, 10));
    end
    drain();
    total++;
    if (pix_opaque !== 1'b0 || pix_color !== 12'd0 || pix_valid !== 1'b1) begin
      bad++; $display("FAIL draw_edge32 opaque=%b color=%h valid=%b exp 0 000 1",
                      pix_opaque, pix_color, pix_valid);
    end
    pix(131, 50);
    total++;
    if (rom_addr !== mk(1, 0, 0, 31)) begin
      bad++; $display("FAIL draw_edge31 got=%h exp=%h", rom_addr, mk(1, 0, 0, 31));
    end
    drain();
  endtask

  task automatic test_mirror();
    latch(1, 0, 100, 50, 1'b1);
    pix(100, 50);
    total++;
    if (rom_addr !== mk(1, 0, 0, 31)) begin
      bad++; $display("FAIL mirror_left got=%h exp=%h", rom_addr, mk(1, 0, 0, 31));
    end
    drain();
    total++;
    if (pix_opaque !== 1'b1 || pix_color !== 12'h01F) begin
      bad++; $display("FAIL mirror_pix opaque=%b color=%h exp 1 01f", pix_opaque, pix_color);
    end
    pix(131, 50);
    total++;
    if (rom_addr !== mk(1, 0, 0, 0)) begin
      bad++; $display("FAIL mirror_right got=%h exp=%h", rom_addr, mk(1, 0, 0, 0));
    end
    drain();
  endtask

  task automatic test_keying();
    rom_mode = 1'b1;
    rom_const = 12'hF0F;
    pix(105, 50);
    drain();
    total++;
    if (pix_opaque !== 1'b0 || pix_color !== 12'd0 || pix_valid !== 1'b1) begin
      bad++; $display("FAIL key_transparent opaque=%b color=%h valid=%b exp 0 000 1",
                      pix_opaque, pix_color, pix_valid);
    end
    rom_const = 12'h123;
    pix(105, 50);
    drain();
    total++;
    if (pix_opaque !== 1'b1 || pix_color !== 12'h123) begin
      bad++; $display("FAIL key_solid opaque=%b color=%h exp 1 123", pix_opaque, pix_color);
    end
    pix(300, 50);
    drain();
    total++;
    if (pix_opaque !== 1'b0 || pix_color !== 12'd0) begin
      bad++; $display("FAIL key_outside opaque=%b color=%h exp 0 000", pix_opaque, pix_color);
    end
    rom_mode = 1'b0;
  endtask

  task automatic test_loop();
    logic [17:0] exp;
    latch(5, 0, 100, 50, 1'b0);
    for (int k = 0; k < 30; k++) begin
      latch(1, 0, 100, 50, 1'b0);
      pix(100, 50);
      exp = mk(1, (k / 6) % 4, 0, 0);
      total++;
      if (rom_addr !== exp) begin
        bad++; $display("FAIL loop_walk k=%0d got=%h exp=%h", k, rom_addr, exp);
      end
    end
    for (int k = 0; k < 13; k++) begin
      latch(0, 0, 100, 50, 1'b0);
      pix(100, 50);
      exp = mk(0, (k / 6) % 2, 0, 0);
      total++;
      if (rom_addr !== exp) begin
        bad++; $display("FAIL loop_idle k=%0d got=%h exp=%h", k, rom_addr, exp);
      end
    end
    drain();
  endtask

  task automatic test_attack();
    latch(3, 13, 100, 50, 1'b0);
    pix(100, 50);
    total++;
    if (rom_addr !== mk(3, 3, 0, 0)) begin
      bad++; $display("FAIL atk_frame13 got=%h exp=%h", rom_addr, mk(3, 3, 0, 0));
    end
    latch(2, 7, 100, 50, 1'b0);
    pix(100, 50);
    total++;
    if (rom_addr !== mk(2, 1, 0, 0)) begin
      bad++; $display("FAIL jump_frame7 got=%h exp=%h", rom_addr, mk(2, 1, 0, 0));
    end
    latch(3, 40, 100, 50, 1'b0);
    pix(100, 50);
    total++;
    if (rom_addr !== mk(3, 7, 0, 0)) begin
      bad++; $display("FAIL atk_saturate got=%h exp=%h", rom_addr, mk(3, 7, 0, 0));
    end
    anim_state = 4'd4; anim_frame = 6'd0; pos_x = 10'd500; pos_y = 10'd400; facing = 1'b1;
    tick();
    pix(101, 51);
    total++;
    if (rom_addr !== mk(3, 7, 1, 1)) begin
      bad++; $display("FAIL tear_free got=%h exp=%h", rom_addr, mk(3, 7, 1, 1));
    end
    // frame_start together with a visible pixel: that pixel still sees the old shadow.
    anim_state = 4'd5; pos_x = 10'd100; pos_y = 10'd50; facing = 1'b0;
    frame_start = 1'b1;
    pix(102, 50);
    frame_start = 1'b0;
    total++;
    if (rom_addr !== mk(3, 7, 0, 2)) begin
      bad++; $display("FAIL latch_coincide got=%h exp=%h", rom_addr, mk(3, 7, 0, 2));
    end
    pix(102, 50);
    total++;
    if (rom_addr !== mk(5, 0, 0, 2)) begin
      bad++; $display("FAIL latch_after got=%h exp=%h", rom_addr, mk(5, 0, 0, 2));
    end
    latch(9, 20, 100, 50, 1'b0);
    pix(101, 50);
    total++;
    if (rom_addr !== mk(0, 0, 0, 1)) begin
      bad++; $display("FAIL sanitise got=%h exp=%h", rom_addr, mk(0, 0, 0, 1));
    end
    drain();
  endtask

  task automatic test_clip();
    latch(1, 0, 1010, 50, 1'b0);
    pix(1010, 50);
    total++;
    if (rom_addr !== mk(1, 0, 0, 0)) begin
      bad++; $display("FAIL clip_addr1010 got=%h exp=%h", rom_addr, mk(1, 0, 0, 0));
    end
    drain();
    total++;
    if (pix_opaque !== 1'b1) begin
      bad++; $display("FAIL clip_pix1010 opaque=%b exp 1", pix_opaque);
    end
    pix(1023, 50);
    drain();
    total++;
    if (pix_opaque !== 1'b1 || pix_color !== 12'd13) begin
      bad++; $display("FAIL clip_pix1023 opaque=%b color=%h exp 1 00d", pix_opaque, pix_color);
    end
    for (int h = 0; h <= 20; h += 20) begin
      pix(h, 50);
      drain();
      total++;
      if (pix_opaque !== 1'b0 || pix_valid !== 1'b1) begin
        bad++; $display("FAIL clip_nowrap h=%0d opaque=%b valid=%b exp 0 1", h, pix_opaque, pix_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int h;
    latch(1, 0, 100, 50, 1'b0);
    pix_en = 1'b1;
    vcount = 10'd50;
    for (int i = 0; i < 12; i++) begin
      hcount = 10'(96 + i);
      tick();
      if (i >= 2) begin
        h = 96 + i - 2;
        total++;
        if (pix_valid !== 1'b1 || pix_opaque !== (h >= 100) ||
            pix_color !== ((h >= 100) ? 12'(h - 100) : 12'd0)) begin
          bad++; $display("FAIL b2b h=%0d valid=%b opaque=%b color=%h", h, pix_valid, pix_opaque, pix_color);
        end
      end
    end
    pix_en = 1'b0;
    hcount = 10'd1000;
    vcount = 10'd1000;
    drain();
  endtask

  task automatic test_reset_mid();
    pix_en = 1'b1;
    vcount = 10'd50;
    for (int i = 0; i < 4; i++) begin
      hcount = 10'(100 + i);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (rom_addr !== 18'd0 || pix_color !== 12'd0 || pix_opaque !== 1'b0 || pix_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid addr=%h color=%h opaque=%b valid=%b exp all 0",
               rom_addr, pix_color, pix_opaque, pix_valid);
    end
    pix_en = 1'b0;
    #1 reset = 1'b0;
    tick();
    pix(5, 7);
    total++;
    if (rom_addr !== mk(0, 0, 7, 5) || pix_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mid_shadow addr=%h valid=%b exp %h 0", rom_addr, pix_valid, mk(0, 0, 7, 5));
    end
    drain();
    total++;
    if (pix_opaque !== 1'b1 || pix_color !== 12'd5 || pix_valid !== 1'b1) begin
      bad++; $display("FAIL reset_mid_recover opaque=%b color=%h valid=%b exp 1 005 1",
                      pix_opaque, pix_color, pix_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_draw();
    test_mirror();
    test_keying();
    test_loop();
    test_attack();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_sprite_render.md
# player_sprite_render

Consumer of the per-player animation stream (`anim_state`, `anim_frame`) and the drawing end of that interface. It snapshots the player's animation and position once per video frame, maps them to a sprite-ROM frame index, and walks a pipelined ROM lookup against the VGA raster. Per pixel it outputs a color plus an opaque flag for the compositor. One instance per player sits between the game-logic domain and the video mixer.

## Interface
Parameters:
- `COL_W`, 5: sprite width = 2^COL_W pixels (32)
- `ROW_W`, 6: sprite height = 2^ROW_W rows (64)
- `FRM_W`, 3: frames per state = 2^FRM_W (8)
- `FRAME_SHIFT`, 2: right shift applied to `anim_frame` for the ATK1, ATK2 and JUMP states
- `LOOP_DIV`, 6: video frames per looped-animation step
- `TRANSPARENT`, 12'hF0F: color key meaning "no pixel"

Ports:
- `clk`, in, 1: clock
- `reset`, in, 1: asynchronous, active-high
- `frame_start`, in, 1: one-cycle pulse at the start of vertical blanking
- `pix_en`, in, 1: hcount/vcount are a visible pixel this cycle
- `hcount`, in, 10: raster column
- `vcount`, in, 10: raster row
- `anim_state`, in, 4: 0 IDLE, 1 WALK, 2 JUMP, 3 ATK1, 4 ATK2, 5 HIT, 6 LOSE
- `anim_frame`, in, 6: producer frame counter
- `pos_x`, in, 10: sprite top-left x
- `pos_y`, in, 10: sprite top-left y
- `facing`, in, 1: 1 = facing left, so columns are mirrored
- `rom_addr`, out, 4+FRM_W+ROW_W+COL_W: {state, frame, row, col}
- `rom_data`, in, 12: synchronous ROM output; valid the cycle after `rom_addr`
- `pix_color`, out, 12: RGB444
- `pix_opaque`, out, 1: pixel belongs to the sprite and is not keyed out
- `pix_valid`, out, 1: `pix_en` delayed to align with the outputs

## Operation
- **Shadow latch.** On `frame_start`, capture `anim_state`, `anim_frame`, `pos_x`, `pos_y` and `facing` into shadow registers. All rendering uses the shadow values, so the sprite never tears mid-frame.
- **State sanitising.** `anim_state` > 6 is latched as IDLE (0).
- **Loop counter.** Advances only on `frame_start` and drives the frame index for IDLE and WALK.
  - `div_ctr` counts 0..LOOP_DIV-1.
  - On wrap of `div_ctr`, `loop_idx` increments.
  - `loop_idx` runs modulo 4 in WALK and modulo 2 in IDLE.
  - If the newly latched state differs from the previous shadow state, `div_ctr` and `loop_idx` clear to 0 on that same `frame_start`.
- **Frame index, resolved at latch time:**
  - IDLE / WALK: `loop_idx`
  - JUMP / ATK1 / ATK2: `anim_frame >> FRAME_SHIFT`, saturated to 2^FRM_W−1
  - HIT / LOSE: 0
- **Stage 1 (registered).**
  - dx = hcount − sx and dy = vcount − sy, computed at 11-bit width.
  - in_box = both differences non-negative, dx < 2^COL_W and dy < 2^ROW_W.
  - col = facing ? (2^COL_W−1−dx) : dx.
  - `rom_addr` = {state, frame, dy[ROW_W-1:0], col}.
  - If in_box = 0, `rom_addr` is held at its previous value. This is don't-care but must not toggle.
- **Stage 2.** Delay in_box and `pix_en` by one cycle while the ROM responds.
- **Stage 3 (registered outputs).**
  - `pix_opaque` = in_box_d2 & (`rom_data` ≠ TRANSPARENT) & pix_en_d2.
  - `pix_color` = `rom_data` when opaque, else 0.
  - `pix_valid` = pix_en_d2.
- **Pipeline behaviour.** The pipeline runs every clock; it is not stalled by `pix_en`.

## Timing
- **Reset values:** all outputs 0; shadow state IDLE; shadow position 0; facing 0; `div_ctr` and `loop_idx` 0; pipeline valid bits 0.
- **Latency:** inputs sampled at edge N; `rom_addr` valid after edge N; `rom_data` valid after edge N+1; `pix_*` valid after edge N+2. This is 3 cycles from the sampled raster cycle to the output cycle and is fixed.
- **Latch visibility.** Values latched at a `frame_start` edge affect the pixel sampled on the next edge and all following pixels.
- **`frame_start` coinciding with `pix_en`.** Legal but not expected. The pixel sampled that cycle uses the old shadow values.
- **Asynchronous reset mid-frame** clears the pipeline immediately; outputs stay 0 until the next valid pixel has traversed the 3 stages.
- **Boundaries:**
  - pos_x near 1023: dx wraps to a large 11-bit value, so in_box = 0 and the sprite clips right. There is no wrap to the left edge.
  - dx = 2^COL_W−1 is in the box; dx = 2^COL_W is not.

## Test plan
- **Basic draw.** Latch pos (100,50), state WALK, facing 0; ROM returns {col} pattern. At hcount=100, vcount=50: `rom_addr` col=0 and row=0, then `pix_opaque`=1 three cycles later. At hcount=132: opaque=0.
- **Mirror.** facing=1, hcount=100 → `rom_addr` col field = 31. hcount=131 → col = 0.
- **Keying.** `rom_data`=12'hF0F inside the box → `pix_opaque`=0 and `pix_color`=0. `rom_data`=12'h123 → opaque=1 and color=12'h123.
- **Loop timing.** Hold WALK for 30 frame_starts with LOOP_DIV=6 → frame field sequence 0,1,2,3,0, stepping every 6 frames. Switch to IDLE → frame 0 on the same latch; after 12 more frames → 0,1,0.
- **Attack mapping and tear-free latch.**
  - ATK1 with `anim_frame`=13 → frame 3.
  - `anim_frame`=40 → frame 7 (saturated).
  - Change inputs mid-frame without `frame_start` → `rom_addr` state and frame fields unchanged until the next pulse.
- **Reset and clipping.**
  - Assert reset mid-line → all outputs 0 the same cycle; shadow state reads IDLE.
  - pos_x=1010 → pixels at hcount 1010..1023 drawn, hcount 0..20 not drawn.
